// File: rtl/fetch_pkg.sv
// fetch_pkg: shared widths, reset address, FSM encoding and queue entry layout for the fetch front end
package fetch_pkg;

    localparam int ADDR_W_DEF   = 12;
    localparam int INSTR_W_DEF  = 19;
    localparam int RESET_PC_DEF = 0;

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } state_t;

    typedef struct packed {
        logic [INSTR_W_DEF-1:0] instr;
        logic [ADDR_W_DEF-1:0]  pc;
    } entry_t;

endpackage

// File: rtl/fetch_skid_queue.sv
// fetch_skid_queue: 2-entry FIFO holding returned {instr, pc} words; flush discards everything
module fetch_skid_queue
    import fetch_pkg::*;
#(
    parameter int W = $bits(entry_t)
) (
    input  logic         clock,
    input  logic         reset_n,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    input  logic         flush,
    output logic [W-1:0] head,
    output logic [1:0]   count
);

    logic [W-1:0] mem [2];
    logic         wr_ptr;
    logic         rd_ptr;

    assign head = mem[rd_ptr];

    // storage and pointers; a flush outranks any push arriving in the same cycle
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else if (flush) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop)
                rd_ptr <= ~rd_ptr;
            count <= count + 2'(push) - 2'(pop);
        end
    end

endmodule

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: PC owner and fetch controller for a 1-cycle registered instruction memory.
// Optional FETCH_SEQUENCER_PERF_EN adds saturating fetch_count / stall_count outputs.
module fetch_sequencer
    import fetch_pkg::*;
#(
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int INSTR_W  = INSTR_W_DEF,
    parameter int RESET_PC = RESET_PC_DEF
) (
    input  logic               clock,
    input  logic               reset_n,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic [INSTR_W-1:0] imem_instr,
    output logic               instr_valid,
    input  logic               instr_ready,
    output logic [INSTR_W-1:0] instr,
    output logic [ADDR_W-1:0]  instr_pc,
    input  logic               branch_valid,
    input  logic [ADDR_W-1:0]  branch_target,
    input  logic               halt_req,
`ifdef FETCH_SEQUENCER_PERF_EN
    output logic [15:0]        fetch_count,
    output logic [15:0]        stall_count,
`endif
    output logic               halted
);

    state_t              state;
    state_t              state_nxt;
    logic [ADDR_W-1:0]   pc;
    logic                inflight;
    logic [ADDR_W-1:0]   inflight_pc;
    logic [1:0]          count;
    logic                pop;
    logic                push;
    logic                issue;
    logic                room;

    assign imem_addr   = pc;
    assign instr_valid = (count != 2'd0);
    assign pop         = instr_valid & instr_ready;
    assign push        = inflight & ~branch_valid;
    assign room        = (3'(count) + 3'(inflight) - 3'(pop)) < 3'd2;
    assign halted      = (state == HALT) & (count == 2'd0) & ~inflight;

    // next state follows halt_req; a fetch needs RUN, no halt request, no redirect and a free slot
    always_comb begin
        state_nxt = state;
        issue     = 1'b0;
        state_nxt = halt_req ? HALT : RUN;
        issue     = (state == RUN) & ~halt_req & ~branch_valid & room;
    end

    // state register
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)
            state <= RUN;
        else
            state <= state_nxt;
    end

    // program counter and in-flight tracking; a redirect drops the returning word
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pc          <= ADDR_W'(RESET_PC);
            inflight    <= 1'b0;
            inflight_pc <= '0;
        end else if (branch_valid) begin
            pc       <= branch_target;
            inflight <= 1'b0;
        end else if (issue) begin
            pc          <= pc + ADDR_W'(1);
            inflight    <= 1'b1;
            inflight_pc <= pc;
        end else begin
            inflight <= 1'b0;
        end
    end

    fetch_skid_queue #(
        .W(INSTR_W + ADDR_W)
    ) u_queue (
        .clock     (clock),
        .reset_n   (reset_n),
        .push      (push),
        .push_data ({imem_instr, inflight_pc}),
        .pop       (pop),
        .flush     (branch_valid),
        .head      ({instr, instr_pc}),
        .count     (count)
    );

`ifdef FETCH_SEQUENCER_PERF_EN
    // saturating counters of delivered instructions and starved RUN cycles
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            fetch_count <= 16'd0;
            stall_count <= 16'd0;
        end else begin
            if (pop && fetch_count != 16'hFFFF)
                fetch_count <= fetch_count + 16'd1;
            if (state == RUN && !instr_valid && stall_count != 16'hFFFF)
                stall_count <= stall_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer: scoreboard bench; stimulus queues expected {instr, pc}, a monitor checks every pop
module tb_fetch_sequencer;

    logic        clock;
    logic        reset_n;
    logic [11:0] imem_addr;
    logic [18:0] imem_instr;
    logic        instr_valid;
    logic        instr_ready;
    logic [18:0] instr;
    logic [11:0] instr_pc;
    logic        branch_valid;
    logic [11:0] branch_target;
    logic        halt_req;
    logic        halted;
`ifdef FETCH_SEQUENCER_PERF_EN
    logic [15:0] fetch_count;
    logic [15:0] stall_count;
`endif

    typedef struct {
        logic [18:0] i;
        logic [11:0] p;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        e;
    logic [18:0] mem [4096];
    int          total = 0;
    int          bad   = 0;

    fetch_sequencer dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .imem_addr     (imem_addr),
        .imem_instr    (imem_instr),
        .instr_valid   (instr_valid),
        .instr_ready   (instr_ready),
        .instr         (instr),
        .instr_pc      (instr_pc),
        .branch_valid  (branch_valid),
        .branch_target (branch_target),
        .halt_req      (halt_req),
`ifdef FETCH_SEQUENCER_PERF_EN
        .fetch_count   (fetch_count),
        .stall_count   (stall_count),
`endif
        .halted        (halted)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    always @(posedge clock) imem_instr <= mem[imem_addr];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    task automatic expect_word(input logic [18:0] i, input logic [11:0] p);
        exp_t x;
        x.i = i;
        x.p = p;
        exp_q.push_back(x);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    always @(negedge clock) begin
        if (reset_n && instr_valid && instr_ready) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_pop: got instr=%0d pc=%0d expected none", instr, instr_pc);
            end else begin
                e = exp_q.pop_front();
                check("pop_instr", 32'(instr), 32'(e.i));
                check("pop_pc", 32'(instr_pc), 32'(e.p));
            end
        end
    end

    initial begin
        for (int i = 0; i < 4096; i++) mem[i] = 19'(i + 1000);
        mem[0]   = 19'd17;
        mem[1]   = 19'd18;
        mem[2]   = 19'd19;
        mem[3]   = 19'd21;
        mem[100] = 19'd30;
        reset_n       = 1'b0;
        instr_ready   = 1'b1;
        branch_valid  = 1'b0;
        branch_target = '0;
        halt_req      = 1'b0;
        #12;
        check("rst_valid", 32'(instr_valid), 0);
        check("rst_instr", 32'(instr), 0);
        check("rst_pc", 32'(instr_pc), 0);
        check("rst_halted", 32'(halted), 0);
        check("rst_addr", 32'(imem_addr), 0);
        @(posedge clock);
        #3;
        reset_n = 1'b1;
        expect_word(17, 0);
        expect_word(18, 1);
        expect_word(19, 2);
        expect_word(21, 3);
        tick(1);
        check("first_not_yet", 32'(instr_valid), 0);
        tick(1);
        check("first_valid", 32'(instr_valid), 1);
        check("first_pc", 32'(instr_pc), 0);
        tick(4);
        instr_ready = 1'b0;
        tick(4);
        check("stall_addr", 32'(imem_addr), 6);
        check("stall_valid", 32'(instr_valid), 1);
        check("stall_head", 32'(instr), 1004);
        check("stall_head_pc", 32'(instr_pc), 4);
        branch_valid  = 1'b1;
        branch_target = 12'd100;
        instr_ready   = 1'b1;
        expect_word(1004, 4);
        expect_word(30, 100);
        expect_word(1101, 101);
        expect_word(1102, 102);
        tick(1);
        branch_valid = 1'b0;
        check("br_flush1", 32'(instr_valid), 0);
        tick(1);
        check("br_flush2", 32'(instr_valid), 0);
        tick(4);
        instr_ready = 1'b0;
        tick(3);
        halt_req    = 1'b1;
        instr_ready = 1'b1;
        expect_word(1103, 103);
        expect_word(1104, 104);
        tick(1);
        check("halt_draining", 32'(halted), 0);
        tick(1);
        check("halt_done", 32'(halted), 1);
        check("halt_empty", 32'(instr_valid), 0);
        tick(2);
        check("halt_addr", 32'(imem_addr), 105);
        check("halt_hold", 32'(halted), 1);
        halt_req = 1'b0;
        expect_word(1105, 105);
        expect_word(1106, 106);
        tick(1);
        check("resume_halted", 32'(halted), 0);
        tick(4);
        instr_ready = 1'b0;
        tick(2);
        branch_valid  = 1'b1;
        branch_target = 12'd4095;
        instr_ready   = 1'b1;
        expect_word(1107, 107);
        expect_word(5095, 4095);
        expect_word(17, 0);
        expect_word(18, 1);
        tick(1);
        branch_valid = 1'b0;
        check("wrap_flush", 32'(instr_valid), 0);
        tick(5);
        instr_ready = 1'b0;
        tick(2);
        check("pre_rst_valid", 32'(instr_valid), 1);
        #2;
        reset_n = 1'b0;
        #1;
        check("async_rst_valid", 32'(instr_valid), 0);
        check("async_rst_instr", 32'(instr), 0);
        check("async_rst_addr", 32'(imem_addr), 0);
        check("async_rst_halted", 32'(halted), 0);
        #3;
        reset_n     = 1'b1;
        instr_ready = 1'b1;
        expect_word(17, 0);
        expect_word(18, 1);
        tick(4);
        instr_ready = 1'b0;
        tick(3);
        check("scoreboard_drained", 32'(exp_q.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
